// File: rtl/spi_slave_pkg.sv
// Shared types and sizing for the SPI slave: FSM state encoding, byte width
// and synchronizer depth.
package spi_pkg;

    localparam int SPI_BYTE_W      = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_t;

endpackage

// File: rtl/spi_slave_if.sv
// Bundle of SPI pins plus the parallel byte-side handshake of the SPI slave.
// The slave modport is the DUT view; the master modport is the bench/host view.
interface spi_slave_if;
    import spi_pkg::*;

    logic                  cs;
    logic                  sclk;
    logic                  mosi;
    logic                  miso;
    logic                  miso_oe;
    logic [SPI_BYTE_W-1:0] tx_data;
    logic                  tx_req;
    logic [SPI_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  abort;

    modport slave (
        input  cs, sclk, mosi, tx_data,
        output miso, miso_oe, tx_req, rx_data, rx_valid, abort
    );

    modport master (
        output cs, sclk, mosi, tx_data,
        input  miso, miso_oe, tx_req, rx_data, rx_valid, abort
    );

endinterface

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer for asynchronous inputs; each bit resets to its own
// value from RESET_VAL so idle pin levels are presented during reset.
module spi_sync
    import spi_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [SPI_SYNC_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SPI_SYNC_STAGES; i++) begin
                stages[i] <= RESET_VAL;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < SPI_SYNC_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[SPI_SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, oversampled by the system clock. Define
// SPI_SLAVE_LSB_FIRST_EN for LSB-first bit order (default MSB first).
module spi_slave
    import spi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);

    localparam int                 CNT_W    = $clog2(SPI_BYTE_W);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SPI_BYTE_W - 1);
    localparam logic [1:0]         SETTLE   = 2'(SPI_SYNC_STAGES);

    spi_state_t            state, state_next;
    logic [2:0]            sync_q;
    logic                  cs_s, sclk_s, mosi_s;
    logic                  cs_d, sclk_d;
    logic                  cs_fall, sclk_rise, sclk_fall;
    logic [1:0]            settle_cnt;
    logic                  armed;
    logic [CNT_W-1:0]      bit_cnt;
    logic [SPI_BYTE_W-2:0] tx_sr;
    logic [SPI_BYTE_W-2:0] rx_sr;
    logic                  miso_r;
    logic                  do_load, do_sample, do_shift, do_abort;
    logic [SPI_BYTE_W-1:0] rx_next;
    logic [SPI_BYTE_W-2:0] tx_load_rest, tx_shift_next;
    logic                  tx_first, tx_out;

    spi_sync #(.WIDTH(3), .RESET_VAL(3'b100)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({bus.cs, bus.sclk, bus.mosi}),
        .q   (sync_q)
    );

    assign cs_s      = sync_q[2];
    assign sclk_s    = sync_q[1];
    assign mosi_s    = sync_q[0];
    assign cs_fall   = cs_d & ~cs_s;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;

    // tx_sr holds only the bits not yet driven; miso_r carries the current one.
`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next       = {mosi_s, rx_sr};
    assign tx_first      = bus.tx_data[0];
    assign tx_load_rest  = bus.tx_data[SPI_BYTE_W-1:1];
    assign tx_out        = tx_sr[0];
    assign tx_shift_next = {1'b0, tx_sr[SPI_BYTE_W-2:1]};
`else
    assign rx_next       = {rx_sr, mosi_s};
    assign tx_first      = bus.tx_data[SPI_BYTE_W-1];
    assign tx_load_rest  = bus.tx_data[SPI_BYTE_W-2:0];
    assign tx_out        = tx_sr[SPI_BYTE_W-2];
    assign tx_shift_next = {tx_sr[SPI_BYTE_W-3:0], 1'b0};
`endif

    // A CS level that was already low at reset release must not look like a
    // fresh select, so selection is armed only after CS is seen high post-reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_d       <= 1'b1;
            sclk_d     <= 1'b0;
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else begin
            cs_d   <= cs_s;
            sclk_d <= sclk_s;
            if (settle_cnt != SETTLE) begin
                settle_cnt <= settle_cnt + 2'd1;
            end
            if (settle_cnt == SETTLE && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CS high takes priority over any SCLK edge seen in the same cycle.
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        do_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (armed && cs_fall) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (cs_s) begin
                    state_next = IDLE;
                end else begin
                    state_next = SHIFT;
                    do_load    = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    state_next = IDLE;
                    do_abort   = (bit_cnt != '0);
                end else begin
                    do_sample  = sclk_rise;
                    do_shift   = sclk_fall;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            miso_r      <= 1'b0;
            bus.rx_data <= '0;
            bus.rx_valid <= 1'b0;
            bus.tx_req  <= 1'b0;
            bus.abort   <= 1'b0;
        end else begin
            bus.rx_valid <= 1'b0;
            bus.tx_req   <= 1'b0;
            bus.abort    <= do_abort;
            if (state_next == IDLE) begin
                bit_cnt <= '0;
                miso_r  <= 1'b0;
            end
            if (do_load) begin
                tx_sr      <= tx_load_rest;
                miso_r     <= tx_first;
                bit_cnt    <= '0;
                rx_sr      <= '0;
                bus.tx_req <= 1'b1;
            end
            if (do_sample) begin
                rx_sr   <= rx_next[SPI_BYTE_W-2:0];
`ifdef SPI_SLAVE_LSB_FIRST_EN
                rx_sr   <= rx_next[SPI_BYTE_W-1:1];
`endif
                bit_cnt <= bit_cnt + CNT_W'(1);
                if (bit_cnt == CNT_LAST) begin
                    bus.rx_data  <= rx_next;
                    bus.rx_valid <= 1'b1;
                end
            end
            // Counter at zero on a falling edge means a byte boundary: refill.
            if (do_shift) begin
                if (bit_cnt != '0) begin
                    tx_sr  <= tx_shift_next;
                    miso_r <= tx_out;
                end else begin
                    tx_sr      <= tx_load_rest;
                    miso_r     <= tx_first;
                    bus.tx_req <= 1'b1;
                end
            end
        end
    end

    assign bus.miso    = miso_r;
    assign bus.miso_oe = (state != IDLE);

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bit-banged mode-0 master drives bytes and
// pushes expected received bytes; a monitor pops them on every RX_VALID.
module tb_spi_slave;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_slave_if bus ();

    spi_slave dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int rx_valid_cnt = 0;
    int tx_req_cnt = 0;
    int abort_cnt = 0;
    logic [7:0] rx_q[$];
    logic [7:0] feed_q[$];

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: scoreboard pop on RX_VALID, pulse counting, TX_DATA refill on TX_REQ.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.rx_valid) begin
                    rx_valid_cnt++;
                    if (rx_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL rx_unexpected: got 0x%0h, expected no byte", bus.rx_data);
                    end else begin
                        check_output("rx_data", bus.rx_data, rx_q.pop_front());
                    end
                end
                if (bus.tx_req) begin
                    tx_req_cnt++;
                    if (feed_q.size() != 0) bus.tx_data = feed_q.pop_front();
                end
                if (bus.abort) abort_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] timeout");
    end

    task automatic select_slave();
        bus.cs = 1'b0;
        wait_clk(8);
    endtask

    task automatic deselect_slave();
        wait_clk(8);
        bus.cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic shift_bits(input logic [7:0] mosi_byte, input int nbits,
                              output logic [7:0] got, output logic first);
        got   = '0;
        first = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
`ifdef SPI_SLAVE_LSB_FIRST_EN
            idx = i;
`else
            idx = 7 - i;
`endif
            bus.mosi = mosi_byte[idx];
            wait_clk(4);
            got[idx] = bus.miso;
            if (i == 0) first = bus.miso;
            bus.sclk = 1'b1;
            wait_clk(4);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] mosi_byte, input logic [7:0] exp_miso);
        logic [7:0] got;
        logic first;
        rx_q.push_back(mosi_byte);
        shift_bits(mosi_byte, 8, got, first);
        check_output("miso_byte", got, exp_miso);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_miso_oe"}, bus.miso_oe, 1'b0);
        check_output({tag, "_miso"}, bus.miso, 1'b0);
        check_output({tag, "_rx_data"}, bus.rx_data, 8'h00);
        check_output({tag, "_rx_valid"}, bus.rx_valid, 1'b0);
        check_output({tag, "_tx_req"}, bus.tx_req, 1'b0);
        check_output({tag, "_abort"}, bus.abort, 1'b0);
    endtask

    initial begin
        int rv0, tr0, ab0;
        logic [7:0] got;
        logic first;

        bus.cs      = 1'b1;
        bus.sclk    = 1'b0;
        bus.mosi    = 1'b0;
        bus.tx_data = 8'hA5;
        wait_clk(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(6);

        // Single byte exchange
        rv0 = rx_valid_cnt; tr0 = tx_req_cnt; ab0 = abort_cnt;
        select_slave();
        check_output("miso_oe_selected", bus.miso_oe, 1'b1);
        apply_stimulus(8'h3C, 8'hA5);
        deselect_slave();
        check_output("single_rx_valid_cnt", rx_valid_cnt - rv0, 1);
        check_output("single_tx_req_cnt", tx_req_cnt - tr0, 2);
        check_output("single_abort_cnt", abort_cnt - ab0, 0);
        check_output("single_rx_data", bus.rx_data, 8'h3C);
        check_output("miso_oe_idle", bus.miso_oe, 1'b0);

        // Three-byte burst, TX_DATA refilled on each TX_REQ
        rv0 = rx_valid_cnt; tr0 = tx_req_cnt;
        bus.tx_data = 8'h11;
        feed_q.push_back(8'h22);
        feed_q.push_back(8'h33);
        select_slave();
        apply_stimulus(8'h01, 8'h11);
        apply_stimulus(8'h80, 8'h22);
        apply_stimulus(8'hFF, 8'h33);
        deselect_slave();
        check_output("burst_rx_valid_cnt", rx_valid_cnt - rv0, 3);
        check_output("burst_tx_req_cnt", tx_req_cnt - tr0, 4);

        // Abort after five bits, then a clean byte
        rv0 = rx_valid_cnt; ab0 = abort_cnt;
        select_slave();
        shift_bits(8'hF0, 5, got, first);
        deselect_slave();
        check_output("abort_cnt", abort_cnt - ab0, 1);
        check_output("abort_rx_valid_cnt", rx_valid_cnt - rv0, 0);
        check_output("abort_rx_data_held", bus.rx_data, 8'hFF);
        bus.tx_data = 8'h96;
        select_slave();
        apply_stimulus(8'h5A, 8'h96);
        deselect_slave();
        check_output("post_abort_rx_data", bus.rx_data, 8'h5A);

        // SCLK activity while deselected is ignored
        rv0 = rx_valid_cnt; ab0 = abort_cnt;
        bus.mosi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.sclk = 1'b1;
            wait_clk(4);
            bus.sclk = 1'b0;
            wait_clk(4);
        end
        check_output("desel_miso_oe", bus.miso_oe, 1'b0);
        check_output("desel_rx_valid_cnt", rx_valid_cnt - rv0, 0);
        check_output("desel_abort_cnt", abort_cnt - ab0, 0);

        // Reset in mid-transfer, CS still low at release
        bus.tx_data = 8'h3E;
        select_slave();
        shift_bits(8'hC3, 4, got, first);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        wait_clk(3);
        ab0 = abort_cnt; tr0 = tx_req_cnt;
        rst = 1'b0;
        wait_clk(12);
        check_output("no_reselect_miso_oe", bus.miso_oe, 1'b0);
        check_output("no_reselect_tx_req", tx_req_cnt - tr0, 0);
        bus.cs = 1'b1;
        wait_clk(8);
        bus.tx_data = 8'h7E;
        select_slave();
        apply_stimulus(8'hC3, 8'h7E);
        deselect_slave();
        check_output("post_rst_rx_data", bus.rx_data, 8'hC3);
        check_output("post_rst_abort_cnt", abort_cnt - ab0, 0);

        // First bit on the wire for TX_DATA = 0x01
        bus.tx_data = 8'h01;
        select_slave();
        rx_q.push_back(8'h80);
        shift_bits(8'h80, 8, got, first);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        check_output("first_miso_bit", first, 1'b1);
`else
        check_output("first_miso_bit", first, 1'b0);
`endif
        check_output("order_miso_byte", got, 8'h01);
        deselect_slave();
        check_output("order_rx_data", bus.rx_data, 8'h80);

        wait_clk(10);
        check_output("rx_pending", rx_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
